bp_be_dcache_lce_req_mshr: RTL

Next-generation dcache LCE request handler with num_mshr_p independent miss status holding registers (MSHRs), so several cached or uncached-load misses can be outstanding at once.
- Uncached stores are fire-and-forget and limited by a credit counter.
- Sits between the dcache miss interface and the LCE->CCE request and response channels.
- Issues read/write and uncached requests, tracks fills per MSHR ID, and sends a coh_ack for each cached fill.
- Keeps the coherence-timeout ready throttle.

---
 rtl/bp_be_dcache_lce_req_mshr.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/bp_be_dcache_lce_req_mshr.sv
// Dcache LCE request handler with multiple MSHRs for outstanding cached and
// uncached-load misses, credit-limited uncached stores, and coh_ack return.
module bp_be_dcache_lce_req_mshr #(
    parameter int paddr_width_p = 40,
    parameter int block_offset_width_p = 6,
    parameter int dword_width_p = 64,
    parameter int dcache_assoc_p = 8,
    parameter int num_mshr_p = 4,
    parameter int uc_store_credits_p = 8,
    parameter int timeout_max_limit_p = 4,
    localparam int way_id_width_lp = (dcache_assoc_p > 1) ? $clog2(dcache_assoc_p) : 1,
    localparam int mshr_id_width_lp = (num_mshr_p > 1) ? $clog2(num_mshr_p) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        req_v_i,
    output logic                        req_ready_o,
    input  logic [1:0]                  req_type_i,
    input  logic [paddr_width_p-1:0]    req_addr_i,
    input  logic [1:0]                  req_size_i,
    input  logic [dword_width_p-1:0]    req_data_i,
    input  logic [way_id_width_lp-1:0]  req_way_i,
    output logic                        lce_req_v_o,
    input  logic                        lce_req_ready_i,
    output logic [1:0]                  lce_req_type_o,
    output logic [paddr_width_p-1:0]    lce_req_addr_o,
    output logic [1:0]                  lce_req_size_o,
    output logic [dword_width_p-1:0]    lce_req_data_o,
    output logic [way_id_width_lp-1:0]  lce_req_way_o,
    output logic [mshr_id_width_lp-1:0] lce_req_mshr_o,
    input  logic                        fill_v_i,
    input  logic [mshr_id_width_lp-1:0] fill_mshr_i,
    input  logic                        uc_data_v_i,
    input  logic [mshr_id_width_lp-1:0] uc_data_mshr_i,
    input  logic                        uc_store_done_i,
    output logic                        lce_resp_v_o,
    output logic [paddr_width_p-1:0]    lce_resp_addr_o,
    input  logic                        lce_resp_yumi_i,
    input  logic                        coherence_blocked_i,
    input  logic                        credits_ready_i,
    output logic                        busy_o
);

    typedef enum logic [1:0] {e_free, e_send, e_wait, e_ack} state_e;

    localparam logic [1:0] t_uld = 2'd2;
    localparam logic [1:0] t_ust = 2'd3;
    localparam int credit_width_lp = $clog2(uc_store_credits_p + 1);
    localparam int timeout_width_lp = $clog2(timeout_max_limit_p + 1);
    localparam logic [credit_width_lp-1:0] credit_max_lp = credit_width_lp'(uc_store_credits_p);
    localparam logic [mshr_id_width_lp-1:0] last_id_lp = mshr_id_width_lp'(num_mshr_p - 1);

    state_e                      st_q   [num_mshr_p];
    logic [paddr_width_p-1:0]    addr_q [num_mshr_p];
    logic [1:0]                  type_q [num_mshr_p];
    logic [1:0]                  size_q [num_mshr_p];
    logic [way_id_width_lp-1:0]  way_q  [num_mshr_p];

    logic [mshr_id_width_lp-1:0] ptr_q, lock_id_q;
    logic                        lock_v_q;
    logic [credit_width_lp-1:0]  credits_q;
    logic [timeout_width_lp-1:0] tcnt_q;

    logic free_found, conflict, any_valid, ack_found, rr_found;
    logic [mshr_id_width_lp-1:0] free_idx, ack_idx, rr_idx, win;
    logic send_any, timeout, alloc, uc_fire, entry_hs;
    int   j;

    always_comb begin
        free_found = 1'b0;
        free_idx = '0;
        conflict = 1'b0;
        any_valid = 1'b0;
        ack_found = 1'b0;
        ack_idx = '0;
        for (int i = num_mshr_p - 1; i >= 0; i--) begin
            if (st_q[i] == e_free) begin
                free_found = 1'b1;
                free_idx = mshr_id_width_lp'(i);
            end
            if (st_q[i] == e_ack) begin
                ack_found = 1'b1;
                ack_idx = mshr_id_width_lp'(i);
            end
            if (st_q[i] != e_free) begin
                any_valid = 1'b1;
                if (addr_q[i][paddr_width_p-1:block_offset_width_p]
                    == req_addr_i[paddr_width_p-1:block_offset_width_p])
                    conflict = 1'b1;
            end
        end
    end

    always_comb begin
        rr_found = 1'b0;
        rr_idx = '0;
        j = 0;
        for (int k = 0; k < num_mshr_p; k++) begin
            j = (int'(ptr_q) + k) % num_mshr_p;
            if (!rr_found && st_q[j] == e_send) begin
                rr_found = 1'b1;
                rr_idx = mshr_id_width_lp'(j);
            end
        end
    end

    // A stalled winner is locked so a newly allocated entry cannot displace it.
    assign send_any = lock_v_q | rr_found;
    assign win = lock_v_q ? lock_id_q : rr_idx;
    assign entry_hs = send_any & lce_req_ready_i;
    assign timeout = coherence_blocked_i
        & (tcnt_q == timeout_width_lp'(timeout_max_limit_p - 1));

    always_comb begin
        if (req_type_i == t_ust)
            req_ready_o = reset_n_i & (credits_q != '0) & lce_req_ready_i
                & credits_ready_i & ~timeout & ~send_any;
        else
            req_ready_o = reset_n_i & free_found & ~conflict
                & credits_ready_i & ~timeout;
    end

    assign alloc = req_v_i & req_ready_o & (req_type_i != t_ust);
    assign uc_fire = req_v_i & req_ready_o & (req_type_i == t_ust);

    always_comb begin
        lce_req_v_o = send_any | uc_fire;
        lce_req_type_o = '0;
        lce_req_addr_o = '0;
        lce_req_size_o = '0;
        lce_req_data_o = '0;
        lce_req_way_o = '0;
        lce_req_mshr_o = '0;
        if (send_any) begin
            lce_req_type_o = type_q[win];
            lce_req_addr_o = addr_q[win];
            lce_req_size_o = size_q[win];
            lce_req_way_o = way_q[win];
            lce_req_mshr_o = win;
        end else if (uc_fire) begin
            lce_req_type_o = t_ust;
            lce_req_addr_o = req_addr_i;
            lce_req_size_o = req_size_i;
            lce_req_data_o = req_data_i;
            lce_req_way_o = req_way_i;
        end
    end

    assign lce_resp_v_o = ack_found;
    assign lce_resp_addr_o = ack_found ? addr_q[ack_idx] : '0;
    assign busy_o = any_valid | (credits_q != credit_max_lp);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_mshr_p; i++) begin
                st_q[i] <= e_free;
                addr_q[i] <= '0;
                type_q[i] <= '0;
                size_q[i] <= '0;
                way_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < num_mshr_p; i++) begin
                unique case (st_q[i])
                    e_free:
                        if (alloc && free_idx == mshr_id_width_lp'(i)) begin
                            st_q[i] <= e_send;
                            addr_q[i] <= req_addr_i;
                            type_q[i] <= req_type_i;
                            size_q[i] <= req_size_i;
                            way_q[i] <= req_way_i;
                        end
                    e_send:
                        if (entry_hs && win == mshr_id_width_lp'(i))
                            st_q[i] <= e_wait;
                    e_wait:
                        if (fill_v_i && fill_mshr_i == mshr_id_width_lp'(i)
                            && type_q[i] != t_uld)
                            st_q[i] <= e_ack;
                        else if (uc_data_v_i && uc_data_mshr_i == mshr_id_width_lp'(i)
                            && type_q[i] == t_uld)
                            st_q[i] <= e_free;
                    e_ack:
                        if (lce_resp_yumi_i && ack_idx == mshr_id_width_lp'(i))
                            st_q[i] <= e_free;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_q <= '0;
            lock_v_q <= 1'b0;
            lock_id_q <= '0;
            credits_q <= credit_max_lp;
            tcnt_q <= '0;
        end else begin
            lock_v_q <= send_any & ~lce_req_ready_i;
            lock_id_q <= win;
            if (entry_hs)
                ptr_q <= (win == last_id_lp) ? '0 : win + 1'b1;
            if (uc_fire && !uc_store_done_i)
                credits_q <= credits_q - 1'b1;
            else if (!uc_fire && uc_store_done_i && credits_q != credit_max_lp)
                credits_q <= credits_q + 1'b1;
            if (!coherence_blocked_i || timeout)
                tcnt_q <= '0;
            else
                tcnt_q <= tcnt_q + 1'b1;
        end
    end

    fill_in_wait_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        fill_v_i |-> st_q[fill_mshr_i] == e_wait);
    credit_overflow_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        uc_store_done_i |-> credits_q != credit_max_lp);

endmodule
